droute_xbar: RTL
================

Name: droute_xbar

Overview:
Parametrised AXI-Stream route switch, the successor to the fixed 5-in/8-out data route.
- Any of NUM_OUT outputs selects any of NUM_IN equal-width inputs through a runtime switch word.
- Fan-out (broadcast) is supported: an input advances only when every output that selects it can accept.
- Switch changes are applied safely: input is stalled and in-flight beats drain first.
- Sits between the DMA/data generators and the systolic array, PE-buffer and writeback consumers.

Parameters:
NUM_IN, 5, number of slave stream inputs (1..16)
NUM_OUT, 8, number of master stream outputs (1..16)
DATA_W, 1536, tdata width of every port in bits
SEL_W, 4, bits per output select field; must satisfy 2^SEL_W > NUM_IN
RESET_SWITCH, all ones, active switch word after reset (all outputs disconnected)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cfg_switch  in  NUM_OUT*SEL_W  requested switch word; field o (bits o*SEL_W +: SEL_W) = source index for output o; a value >= NUM_IN means disconnected
cfg_load  in  1  one-cycle request to apply cfg_switch
cfg_busy  out  1  high while a switch change is in progress
s_tdata  in  NUM_IN*DATA_W  input data, input i at bits i*DATA_W +: DATA_W
s_tvalid  in  NUM_IN  input valid
s_tready  out  NUM_IN  input ready
m_tdata  out  NUM_OUT*DATA_W  output data, registered
m_tvalid  out  NUM_OUT  output valid, registered
m_tready  in  NUM_OUT  output ready

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - active_sel <= RESET_SWITCH; pending_sel <= RESET_SWITCH.
  - All output buffers emptied; m_tvalid=0; m_tdata=0.
  - cfg_busy=0; state=RUN.
  - s_tready=0 during reset and for as long as no output selects the input.
- Output buffer: one 2-entry skid FIFO per output.
  - space_o = (count_o < 2).
  - m_tvalid_o = (count_o != 0); m_tdata_o = head entry.
  - Push and pop in the same cycle are both legal.
- Fan-out set F_i = {o : active_sel[o] == i}.
- s_tready[i] = (state==RUN) && F_i non-empty && space_o for every o in F_i.
- Transfer on input i (s_tvalid[i] && s_tready[i]): the beat is pushed into every output in F_i in the same cycle.
- Latency: beat appears on m_tdata the cycle after the input handshake.
- Throughput: 1 beat/cycle per input with m_tready held high (count stays <= 1).
- Outputs whose field is >= NUM_IN receive nothing; once drained they hold m_tvalid=0.
- Two outputs selecting the same input never receive different beats; per-output beat order equals input order.
- m_tvalid, once high, holds with stable m_tdata until m_tready (AXI-Stream rule).
- Switch FSM:
  - RUN: on cfg_load, pending_sel <= cfg_switch and go to DRAIN. If a handshake occurs in the same cycle, it completes under the old active_sel.
  - DRAIN: all s_tready=0; go to APPLY once every output count==0.
  - APPLY: one cycle; active_sel <= pending_sel; go to RUN.
  - cfg_busy = (state != RUN).
  - cfg_load is ignored while cfg_busy=1.
- Reset mid-DRAIN: buffered beats are discarded and the pending switch is lost; active_sel returns to RESET_SWITCH.

Optional Feature:
Macro: DROUTE_BEAT_CNT_EN.
- Defined:
  - Adds output port beat_cnt (NUM_OUT*32 bits).
  - Per-output 32-bit counter increments on each m_tvalid&&m_tready; wraps 0xFFFFFFFF -> 0.
  - All counters cleared on reset and in the APPLY cycle.
- Undefined: port and counters absent; behaviour otherwise identical.

Test Plan:
1. Reset, cfg_switch selects output0<-in0 and the rest disconnected, cfg_load; 10 beats 0..9 on in0 with m_tready all 1 -> out0 carries 0..9, one per cycle, first beat 1 cycle after handshake; all other m_tvalid stay 0; s_tready[1..4]=0.
2. Broadcast: outputs 0,3,7 <- in2; m_tready[3] low for 5 cycles mid-stream -> s_tready[2] drops after out3 buffer fills; all three outputs receive an identical, complete, in-order sequence.
3. Random m_tready on out4 (random high/low intervals of 0-60 cycles) with in1 streaming 120 beats -> out4 log equals the input file exactly; no duplicates or drops.
4. Switch change mid-stream with out0 stalled: cfg_load -> cfg_busy=1, all s_tready=0 until out0 drains, one APPLY cycle, then the new mapping takes effect; no beat is routed under a mixed mapping.
5. cfg_load asserted while cfg_busy=1 -> ignored; the first request's mapping is applied.
6. rst_n low for 1 cycle during DRAIN -> m_tvalid=0 the next cycle, cfg_busy=0, all outputs disconnected; with DROUTE_BEAT_CNT_EN, beat_cnt=0.

Source files
------------

// File: rtl/droute_xbar.sv
// ---------------------------------------------------------------------------
// droute_xbar
//
// Parametrised AXI-Stream route switch. Every master output picks one of the
// slave inputs through a runtime switch word, so one input may fan out to
// several outputs at once. Each output owns a 2-entry skid FIFO. The FIFO's
// head entry drives m_tdata and its occupancy drives m_tvalid, so both come
// straight from flops.
//
// A broadcast input advances only when every output that selects it has
// room. Outputs whose select field is >= NUM_IN are disconnected and receive
// nothing.
//
// A switch change runs in three phases:
//   1. Every input is stalled.
//   2. All buffered beats drain out.
//   3. The new mapping is applied in a single cycle.
// Because of this, no beat is ever routed under a mix of the old and new
// mappings.
//
// Optional feature (macro DROUTE_BEAT_CNT_EN):
//   Adds port beat_cnt, which holds one 32-bit counter per output. A counter
//   counts accepted output beats and wraps from 0xFFFFFFFF to 0. All counters
//   clear on reset and in the cycle that applies a new switch word.
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset
//   cfg_switch requested switch word; field o (bits o*SEL_W +: SEL_W) is the
//              source input for output o; values >= NUM_IN disconnect it
//   cfg_load   one-cycle request to apply cfg_switch (ignored while busy)
//   cfg_busy   high while a switch change is in progress
//   s_tdata    input data, input i at bits i*DATA_W +: DATA_W
//   s_tvalid   input valid, one bit per input
//   s_tready   input ready, one bit per input
//   m_tdata    output data, output o at bits o*DATA_W +: DATA_W
//   m_tvalid   output valid, one bit per output
//   m_tready   output ready, one bit per output
//   beat_cnt   (DROUTE_BEAT_CNT_EN only) per-output beat counters, 32 bits each
// ---------------------------------------------------------------------------
module droute_xbar #(
  parameter int                         NUM_IN       = 5,
  parameter int                         NUM_OUT      = 8,
  parameter int                         DATA_W       = 1536,
  parameter int                         SEL_W        = 4,
  parameter logic [NUM_OUT*SEL_W-1:0]   RESET_SWITCH = '1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_OUT*SEL_W-1:0]      cfg_switch,
  input  logic                          cfg_load,
  output logic                          cfg_busy,
  input  logic [NUM_IN*DATA_W-1:0]      s_tdata,
  input  logic [NUM_IN-1:0]             s_tvalid,
  output logic [NUM_IN-1:0]             s_tready,
  output logic [NUM_OUT*DATA_W-1:0]     m_tdata,
  output logic [NUM_OUT-1:0]            m_tvalid,
  input  logic [NUM_OUT-1:0]            m_tready
`ifdef DROUTE_BEAT_CNT_EN
  ,
  output logic [NUM_OUT*32-1:0]         beat_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_APPLY
  } state_e;

  state_e                     state_q, state_d;
  logic                       run;
  logic                       apply;

  logic [NUM_OUT*SEL_W-1:0]   active_sel_q, active_sel_d;
  logic [NUM_OUT*SEL_W-1:0]   pending_sel_q, pending_sel_d;

  logic [SEL_W-1:0]           sel_field [NUM_OUT];
  logic [NUM_IN-1:0]          hit       [NUM_OUT];
  logic [NUM_IN-1:0]          fan_any;
  logic [NUM_IN-1:0]          fan_fit;
  logic [NUM_IN-1:0]          xfer;

  logic [NUM_OUT-1:0]         space;
  logic [NUM_OUT-1:0]         push;
  logic [NUM_OUT-1:0]         pop;
  logic [DATA_W-1:0]          push_data [NUM_OUT];
  logic                       all_empty;

  logic [DATA_W-1:0]          mem_q     [NUM_OUT][2];
  logic [NUM_OUT-1:0]         rd_q, rd_d;
  logic [NUM_OUT-1:0]         wr_q, wr_d;
  logic [1:0]                 count_q   [NUM_OUT];
  logic [1:0]                 count_d   [NUM_OUT];

  // Switch FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Switch FSM next-state logic. DRAIN waits on registered occupancy, so the
  // last pop has fully retired before APPLY swaps the mapping.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (cfg_load) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (all_empty) begin
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Switch FSM outputs.
  always_comb begin
    run      = (state_q == ST_RUN);
    apply    = (state_q == ST_APPLY);
    cfg_busy = (state_q != ST_RUN);
  end

  // A request is captured only in RUN, so a second cfg_load during a change
  // cannot overwrite the word that is about to be applied.
  always_comb begin
    pending_sel_d = pending_sel_q;
    active_sel_d  = active_sel_q;
    if (run && cfg_load) begin
      pending_sel_d = cfg_switch;
    end
    if (apply) begin
      active_sel_d = pending_sel_q;
    end
  end

  // Active and pending switch words.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_sel_q  <= RESET_SWITCH;
      pending_sel_q <= RESET_SWITCH;
    end else begin
      active_sel_q  <= active_sel_d;
      pending_sel_q <= pending_sel_d;
    end
  end

  // Slice the active switch word into one select field per output.
  for (genvar go = 0; go < NUM_OUT; go++) begin : g_sel
    assign sel_field[go] = active_sel_q[go*SEL_W +: SEL_W];
  end

  // hit[o][i] marks output o as a member of input i's fan-out set. A field
  // >= NUM_IN matches no input, which is what disconnects an output.
  always_comb begin
    for (int o = 0; o < NUM_OUT; o++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        hit[o][i] = (sel_field[o] == SEL_W'(i));
      end
    end
  end

  // FIFO room. It uses occupancy only, never the same-cycle pop, so ready
  // has no combinational path from m_tready.
  always_comb begin
    for (int o = 0; o < NUM_OUT; o++) begin
      space[o] = (count_q[o] < 2'd2);
    end
  end

  // An input is ready only if it has at least one listener and every one of
  // its listeners has room.
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      fan_any[i] = 1'b0;
      fan_fit[i] = 1'b1;
      for (int o = 0; o < NUM_OUT; o++) begin
        if (hit[o][i]) begin
          fan_any[i] = 1'b1;
          if (!space[o]) begin
            fan_fit[i] = 1'b0;
          end
        end
      end
    end
  end

  assign s_tready = fan_any & fan_fit & {NUM_IN{run & rst_n}};
  assign xfer     = s_tvalid & s_tready;

  // Each output copies the beat of whichever input it selects on a handshake.
  always_comb begin
    for (int o = 0; o < NUM_OUT; o++) begin
      push[o]      = 1'b0;
      push_data[o] = '0;
      for (int i = 0; i < NUM_IN; i++) begin
        if (hit[o][i]) begin
          push[o]      = xfer[i];
          push_data[o] = s_tdata[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Output side: the head entry and occupancy are presented directly.
  always_comb begin
    for (int o = 0; o < NUM_OUT; o++) begin
      m_tvalid[o]                 = (count_q[o] != 2'd0);
      m_tdata[o*DATA_W +: DATA_W] = mem_q[o][rd_q[o]];
      pop[o]                      = m_tvalid[o] & m_tready[o];
    end
  end

  // Skid FIFO pointers and occupancy. Push and pop may happen in the same
  // cycle. A push into a full FIFO cannot occur because ready excludes it.
  always_comb begin
    for (int o = 0; o < NUM_OUT; o++) begin
      count_d[o] = count_q[o] + {1'b0, push[o]} - {1'b0, pop[o]};
      rd_d[o]    = rd_q[o] ^ pop[o];
      wr_d[o]    = wr_q[o] ^ push[o];
    end
  end

  always_comb begin
    all_empty = 1'b1;
    for (int o = 0; o < NUM_OUT; o++) begin
      if (count_q[o] != 2'd0) begin
        all_empty = 1'b0;
      end
    end
  end

  // FIFO storage and pointers. Storage is cleared on reset so that m_tdata
  // reads zero out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q <= '0;
      wr_q <= '0;
      for (int o = 0; o < NUM_OUT; o++) begin
        count_q[o]  <= 2'd0;
        mem_q[o][0] <= '0;
        mem_q[o][1] <= '0;
      end
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      for (int o = 0; o < NUM_OUT; o++) begin
        count_q[o] <= count_d[o];
        if (push[o]) begin
          mem_q[o][wr_q[o]] <= push_data[o];
        end
      end
    end
  end

`ifdef DROUTE_BEAT_CNT_EN
  logic [31:0] beat_cnt_q [NUM_OUT];

  // Per-output accepted-beat counters. Every FIFO is empty in APPLY, so the
  // clear there never discards a beat that is being accepted.
  always_ff @(posedge clk) begin
    if (!rst_n || apply) begin
      for (int o = 0; o < NUM_OUT; o++) begin
        beat_cnt_q[o] <= '0;
      end
    end else begin
      for (int o = 0; o < NUM_OUT; o++) begin
        if (pop[o]) begin
          beat_cnt_q[o] <= beat_cnt_q[o] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    for (int o = 0; o < NUM_OUT; o++) begin
      beat_cnt[o*32 +: 32] = beat_cnt_q[o];
    end
  end
`else
  // Without beat counting the switch has no counter state at all.
`endif

endmodule
